// File: rtl/fifo_pkg.sv
// Shared constants and fill-level helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_FIFO_SIZE       = 8;
  localparam int unsigned DEF_SIZE_BITS       = 3;
  localparam int unsigned DEF_ALMOST_FULL_TH  = 6;
  localparam int unsigned DEF_ALMOST_EMPTY_TH = 2;

  // Pointers carry one wrap bit above the address, so the difference is 0..FIFO_SIZE.
  function automatic int unsigned fifo_fill(input int unsigned wr_ptr,
                                            input int unsigned rd_ptr,
                                            input int unsigned size_bits);
    int unsigned mask;
    mask = (32'd1 << (size_bits + 32'd1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Handshake, data and status bundle of fifo_sync; master drives the enables, slave is the FIFO.
interface fifo_sync_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SIZE_BITS  = DEF_SIZE_BITS
);

  logic [DATA_WIDTH-1:0] data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [SIZE_BITS:0]    fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data, write_enable, read_enable,
    input  q, fifo_full, fifo_empty, almost_full, almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  data, write_enable, read_enable,
    output q, fifo_full, fifo_empty, almost_full, almost_empty, fill_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with write-to-read bypass.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_BITS-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Bypass lets a word written to the address being read appear without an extra cycle.
  always_ff @(posedge clock) begin
    if (!reset)    r_rdata <= '0;
    else if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO: pointers, fill count, flags and error pulses around fifo_ram.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read (latency 1).
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_SIZE       = DEF_FIFO_SIZE,
  parameter int unsigned SIZE_BITS       = DEF_SIZE_BITS,
  parameter int unsigned ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
  parameter int unsigned ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic       clock,
  input  logic       reset,
  fifo_sync_if.slave bus
);

  localparam int unsigned PTR_W = SIZE_BITS + 1;

  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, r_fill_count;
  logic                  r_full, r_empty, r_afull, r_aempty, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;
  logic [PTR_W-1:0]      w_wr_ptr_next, w_rd_ptr_next, w_count_next;
  logic                  w_ram_we, w_ram_re;
  logic [SIZE_BITS-1:0]  w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_wr_acc      = bus.write_enable & ~r_full;
  assign w_rd_acc      = bus.read_enable & ~r_empty;
  assign w_wr_ptr_next = r_wr_ptr + PTR_W'(w_wr_acc);
  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_rd_acc);
  assign w_count_next  = PTR_W'(fifo_fill(32'(w_wr_ptr_next), 32'(w_rd_ptr_next), SIZE_BITS));
  assign w_ram_we      = reset & w_wr_acc;

`ifdef FIFO_FWFT_EN
  // Always prefetch the word at the upcoming read pointer so q tracks the head.
  assign w_ram_re    = 1'b1;
  assign w_ram_raddr = w_rd_ptr_next[SIZE_BITS-1:0];
`else
  assign w_ram_re    = reset & w_rd_acc;
  assign w_ram_raddr = r_rd_ptr[SIZE_BITS-1:0];
`endif

  // Flags are registered from the next count so they never see the enables combinationally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_count <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_aempty     <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_fill_count <= w_count_next;
      r_full       <= (w_count_next == PTR_W'(FIFO_SIZE));
      r_empty      <= (w_count_next == '0);
      r_afull      <= (w_count_next >= PTR_W'(ALMOST_FULL_TH));
      r_aempty     <= (w_count_next <= PTR_W'(ALMOST_EMPTY_TH));
      r_overflow   <= bus.write_enable & r_full;
      r_underflow  <= bus.read_enable & r_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (SIZE_BITS)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[SIZE_BITS-1:0]),
    .i_wdata (bus.data),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.q            = w_rdata;
  assign bus.fifo_full    = r_full;
  assign bus.fifo_empty   = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.fill_count   = r_fill_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (default 32x8); honours FIFO_FWFT_EN.
module tb_fifo_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_sync_if #(.DATA_WIDTH(32), .SIZE_BITS(3)) bus ();

  fifo_sync dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d);
    bus.data = d;
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
  endtask

  // Returns the word delivered by one read request in the active read mode.
  task automatic do_read(output logic [31:0] word);
`ifdef FIFO_FWFT_EN
    word = bus.q;
    bus.read_enable = 1'b1;
    tick();
    bus.read_enable = 1'b0;
`else
    bus.read_enable = 1'b1;
    tick();
    bus.read_enable = 1'b0;
    word = bus.q;
`endif
  endtask

  task automatic apply_reset();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (bus.fill_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.fill_count); end
    n_tests++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.fifo_empty); end
    n_tests++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.fifo_full); end
    n_tests++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b exp 1", bus.almost_empty); end
    n_tests++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", bus.almost_full); end
    n_tests++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", bus.overflow, bus.underflow); end
    n_tests++; if (bus.q !== 32'd0) begin n_fail++; $display("FAIL reset_q got %h exp 0", bus.q); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      do_write(32'(17 * i));
      n_tests++; if (bus.fill_count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.fill_count, i); end
      n_tests++; if (bus.almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, bus.almost_full, (i >= 6)); end
      n_tests++; if (bus.almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, bus.almost_empty, (i <= 2)); end
      n_tests++; if (bus.fifo_full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.fifo_full, (i == 8)); end
    end
    n_tests++; if (bus.fifo_empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b exp 0", bus.fifo_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    do_write(32'h99);
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", bus.overflow); end
    n_tests++; if (bus.fill_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d exp 8", bus.fill_count); end
    tick();
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    for (int i = 1; i <= 8; i++) begin
      do_read(w);
      n_tests++; if (w !== 32'(17 * i)) begin n_fail++; $display("FAIL drain_q[%0d] got %h exp %h", i, w, 32'(17 * i)); end
      n_tests++; if (bus.fill_count !== 4'(8 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, bus.fill_count, 8 - i); end
    end
    n_tests++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", bus.fifo_empty); end
`ifndef FIFO_FWFT_EN
    tick();
    tick();
    n_tests++; if (bus.q !== 32'h88) begin n_fail++; $display("FAIL q_hold got %h exp 88", bus.q); end
`endif
  endtask

  task automatic test_underflow();
    logic [31:0] w;
    apply_reset();
    do_read(w);
    n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got %b exp 1", bus.underflow); end
    n_tests++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty got %b exp 1", bus.fifo_empty); end
    n_tests++; if (bus.fill_count !== 4'd0) begin n_fail++; $display("FAIL udf_count got %0d exp 0", bus.fill_count); end
`ifndef FIFO_FWFT_EN
    n_tests++; if (bus.q !== 32'd0) begin n_fail++; $display("FAIL udf_q got %h exp 0", bus.q); end
`endif
    tick();
    n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %b exp 0", bus.underflow); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [$];
    logic [31:0] exp_w;
    logic [31:0] next_w;
    apply_reset();
    next_w = 32'h100;
    for (int i = 0; i < 4; i++) begin
      do_write(next_w);
      model.push_back(next_w);
      next_w++;
    end
    n_tests++; if (bus.fill_count !== 4'd4) begin n_fail++; $display("FAIL b2b_start got %0d exp 4", bus.fill_count); end
    for (int c = 0; c < 20; c++) begin
      exp_w = model.pop_front();
`ifdef FIFO_FWFT_EN
      n_tests++; if (bus.q !== exp_w) begin n_fail++; $display("FAIL b2b_q[%0d] got %h exp %h", c, bus.q, exp_w); end
`endif
      bus.data = next_w;
      bus.write_enable = 1'b1;
      bus.read_enable  = 1'b1;
      tick();
      model.push_back(next_w);
      next_w++;
`ifndef FIFO_FWFT_EN
      n_tests++; if (bus.q !== exp_w) begin n_fail++; $display("FAIL b2b_q[%0d] got %h exp %h", c, bus.q, exp_w); end
`endif
      n_tests++; if (bus.fill_count !== 4'd4) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 4", c, bus.fill_count); end
    end
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    n_tests++; if ({bus.fifo_full, bus.fifo_empty} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags got %b%b exp 00", bus.fifo_full, bus.fifo_empty); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 5; i++) do_write(32'h200 + 32'(i));
    n_tests++; if (bus.fill_count !== 4'd5) begin n_fail++; $display("FAIL mrst_pre got %0d exp 5", bus.fill_count); end
    rst = 1'b0;
    bus.data = 32'hDEAD;
    bus.write_enable = 1'b1;
    tick();
    rst = 1'b1;
    bus.write_enable = 1'b0;
    n_tests++; if (bus.fill_count !== 4'd0) begin n_fail++; $display("FAIL mrst_count got %0d exp 0", bus.fill_count); end
    n_tests++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mrst_empty got %b exp 1", bus.fifo_empty); end
    do_write(32'hAA);
    n_tests++; if (bus.fill_count !== 4'd1) begin n_fail++; $display("FAIL mrst_wr got %0d exp 1", bus.fill_count); end
    do_read(w);
    n_tests++; if (w !== 32'hAA) begin n_fail++; $display("FAIL mrst_q got %h exp aa", w); end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    apply_reset();
    do_write(32'h5A);
    n_tests++; if (bus.q !== 32'h5A) begin n_fail++; $display("FAIL fwft_q got %h exp 5a", bus.q); end
    tick();
    n_tests++; if (bus.q !== 32'h5A) begin n_fail++; $display("FAIL fwft_hold got %h exp 5a", bus.q); end
    n_tests++; if (bus.fill_count !== 4'd1) begin n_fail++; $display("FAIL fwft_count got %0d exp 1", bus.fill_count); end
  endtask
`endif

  initial begin
    bus.data         = '0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
